fifo_uart_sequencer: RTL and testbench
======================================

// Module: fifo_uart_sequencer
// PURPOSE
//  Single-clock controller between the UART peripheral and the byte FIFO.
//  - Fill path: captures each received byte and writes it to the FIFO; bytes arriving while full are dropped and counted.
//  - Drain path: while enabled, pops bytes from the FIFO and hands them to the UART transmitter, one at a time.
//  Replaces ad-hoc wr/wclk toggling with defined single-cycle strobes.
// PARAMETERS
//  DATA_W      8   byte width of the rx, tx and FIFO data paths
//  RD_LAT      1   clk cycles from the fifo_rd strobe to valid fifo_datout (>=1)
//  TX_TIMEOUT  16  clk cycles to wait for tx_busy to rise after tx_wr before abandoning the wait (>=2)
//  OVF_W       8   width of the saturating overflow counter
// PORTS
//  clk          in   1       system clock; all logic is on its rising edge
//  rst          in   1       asynchronous, active-low reset
//  rx_data      in   DATA_W  UART received byte; valid when rx_avail=1
//  rx_avail     in   1       UART byte-available; level, may stay high for many cycles
//  tx_data      out  DATA_W  byte presented to the UART transmitter
//  tx_wr        out  1       1-cycle transmit strobe
//  tx_busy      in   1       UART transmitter busy
//  fifo_datin   out  DATA_W  FIFO write data
//  fifo_wr      out  1       1-cycle FIFO write strobe
//  fifo_full    in   1       FIFO full
//  fifo_rd      out  1       1-cycle FIFO read strobe
//  fifo_datout  in   DATA_W  FIFO read data
//  fifo_empy    in   1       FIFO empty
//  drain_en     in   1       1 = drain path allowed to start new bytes
//  ovf_clr      in   1       1-cycle clear of ovf_cnt
//  ovf_cnt      out  OVF_W   count of dropped bytes; saturates at all-ones
//  busy         out  1       1 while the drain FSM is not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - tx_wr=0, fifo_wr=0, fifo_rd=0, tx_data=0, fifo_datin=0, ovf_cnt=0, busy=0.
//   - Drain FSM -> IDLE; rx edge detector armed (previous rx_avail value = 0).
//   - Asserted mid-operation, any in-flight byte is discarded.
//  Fill path (independent of the drain FSM):
//   - Event = rising edge of rx_avail (registered compare), so exactly one event per received byte.
//   - Event with fifo_full=0: next cycle fifo_datin=rx_data (sampled at the event) and fifo_wr=1 for 1 cycle.
//   - Event with fifo_full=1: no write; ovf_cnt+=1, saturating.
//   - Same cycle ovf_clr=1 and an overflow: ovf_cnt=1.
//  Drain FSM states IDLE, POP, WAIT_D, SEND, WAIT_TX:
//   - IDLE:    drain_en=1 & fifo_empy=0 -> POP.
//   - POP:     fifo_rd=1 for exactly 1 cycle -> WAIT_D; latency counter loaded with RD_LAT-1.
//   - WAIT_D:  counter reaches 0 -> latch fifo_datout into tx_data -> SEND.
//   - SEND:    when tx_busy=0, tx_wr=1 for 1 cycle -> WAIT_TX.
//   - WAIT_TX: wait for tx_busy 0->1 and then 1->0, or TX_TIMEOUT cycles with no rise -> IDLE.
//  Drain boundary rules:
//   - Drain handshake is therefore POP -> tx_wr latency = RD_LAT+1 cycles minimum.
//   - drain_en falling mid-transfer: the current byte completes; no new POP.
//   - fifo_empy is sampled only in IDLE; no read is ever issued when empty.
//  Simultaneous events:
//   - fifo_wr and fifo_rd may both assert in the same cycle; this is legal.
//   - A write to a full FIFO in the same cycle as a pop is still dropped (fifo_full is authoritative).
//  Outputs: all registered; no combinational input->output paths.
// STRUCTURE
//  - Shared package fifo_uart_pkg: drain FSM state encoding (3-bit localparams), default DATA_W.
//  - One sub-module, fifo_uart_fill: the rx edge detector, write strobe and overflow counter.
//  - Drain FSM and timers live in the top.
// TESTING
//  1. Reset: hold rst=0 with rx_avail=1 -> all outputs 0. Release -> fifo_wr stays 0 until a new rx_avail rise.
//  2. Fill: rx_data=8'hA5 with rx_avail held high 10 cycles -> exactly one fifo_wr, fifo_datin=8'hA5, one cycle after the rise.
//  3. Overflow: fifo_full=1, 300 rx_avail pulses -> ovf_cnt=8'hFF, no fifo_wr. Pulse ovf_clr -> 0.
//  4. Drain: FIFO model holding 8'h3C, RD_LAT=2, drain_en=1 -> fifo_rd 1 cycle, tx_wr 3 cycles later with tx_data=8'h3C.
//  5. Backpressure/timeout: tx_busy held 1 -> SEND waits with no tx_wr. tx_busy never rises after tx_wr -> IDLE after 16 cycles.
//  6. Concurrency: rx event while drain in POP -> fifo_wr and fifo_rd same cycle. drain_en dropped in WAIT_D -> byte still sent, then busy=0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared drain FSM encoding and default data width for the UART/FIFO sequencer.
package fifo_uart_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    WAIT_D  = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;
endpackage

// File: rtl/fifo_uart_fill.sv
// fifo_uart_fill: rx_avail rise detector, FIFO write strobe and saturating overflow counter.
module fifo_uart_fill #(
  parameter int DATA_W = 8,
  parameter int OVF_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_avail,
  input  logic              fifo_full,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] fifo_datin,
  output logic              fifo_wr,
  output logic [OVF_W-1:0]  ovf_cnt
);
  logic rx_prev;
  logic rx_ev;
  logic ovf;
  assign rx_ev = rx_avail & ~rx_prev;
  assign ovf   = rx_ev & fifo_full;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev    <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_datin <= '0;
      ovf_cnt    <= '0;
    end else begin
      rx_prev <= rx_avail;
      fifo_wr <= rx_ev & ~fifo_full;
      if (rx_ev && !fifo_full) fifo_datin <= rx_data;
      // a clear coinciding with a drop leaves that drop counted
      if (ovf_clr || ovf) ovf_cnt <= ovf_clr ? OVF_W'(ovf) : ovf_cnt + OVF_W'(!(&ovf_cnt));
    end
  end
endmodule

// File: rtl/fifo_uart_sequencer.sv
// fifo_uart_sequencer: fills the FIFO from the UART receiver and drains it into the UART transmitter.
module fifo_uart_sequencer
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int TX_TIMEOUT = 16,
  parameter int OVF_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_avail,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] fifo_datin,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_datout,
  input  logic              fifo_empy,
  input  logic              drain_en,
  input  logic              ovf_clr,
  output logic [OVF_W-1:0]  ovf_cnt,
  output logic              busy
);
  localparam int CNT_W = $clog2((TX_TIMEOUT > RD_LAT ? TX_TIMEOUT : RD_LAT) + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic seen, seen_n;
  fifo_uart_fill #(.DATA_W(DATA_W), .OVF_W(OVF_W)) u_fill (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_avail  (rx_avail),
    .fifo_full (fifo_full),
    .ovf_clr   (ovf_clr),
    .fifo_datin(fifo_datin),
    .fifo_wr   (fifo_wr),
    .ovf_cnt   (ovf_cnt)
  );
  // cnt is the read-latency countdown in WAIT_D and the rise timeout in WAIT_TX
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seen_n  = seen;
    case (state)
      IDLE:    if (drain_en && !fifo_empy) state_n = POP;
      POP: begin
        state_n = WAIT_D;
        cnt_n   = CNT_W'(RD_LAT - 1);
      end
      WAIT_D:  if (cnt == '0) state_n = SEND; else cnt_n = cnt - 1'b1;
      SEND: if (tx_wr) begin
        state_n = WAIT_TX;
        cnt_n   = '0;
        seen_n  = 1'b0;
      end
      WAIT_TX: if (seen) begin
        if (!tx_busy) state_n = IDLE;
      end else if (tx_busy) seen_n = 1'b1;
      else if (cnt == CNT_W'(TX_TIMEOUT - 1)) state_n = IDLE;
      else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // strobes are decided from the next state so they are high during POP / first SEND cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      seen    <= 1'b0;
      fifo_rd <= 1'b0;
      tx_wr   <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      seen    <= seen_n;
      fifo_rd <= state_n == POP;
      tx_wr   <= state_n == SEND && !tx_busy;
      busy    <= state_n != IDLE;
      if (state == WAIT_D && cnt == '0) tx_data <= fifo_datout;
    end
  end
endmodule

// File: tb/tb_fifo_uart_sequencer.sv
// tb_fifo_uart_sequencer: table-driven fill vectors plus directed drain, timeout and concurrency sequences.
module tb_fifo_uart_sequencer;
  typedef struct {
    logic [7:0] data;
    logic       full;
    int         hold;
    logic       clr;
    int         exp_wr;
    logic [7:0] exp_din;
    logic [7:0] exp_ovf;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] rx_data = '0, fifo_datout = '0, tx_data, fifo_datin, ovf_cnt;
  logic rx_avail = 1'b0, fifo_full = 1'b0, drain_en = 1'b0, ovf_clr = 1'b0;
  logic tx_wr, fifo_wr, fifo_rd, fifo_empy, busy, tx_busy;
  logic hold_busy = 1'b0, auto_en = 1'b0;
  int ab_cnt = 0;
  logic [7:0] mem [8];
  logic [7:0] d1 = '0;
  int pushed = 0, popped = 0, rd_empty = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, n_tx = 0, rd_cyc = 0, tx_cyc = 0;
  logic [7:0] last_txd = '0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign tx_busy   = hold_busy | (ab_cnt != 0);
  assign fifo_empy = (pushed == popped);

  fifo_uart_sequencer #(.DATA_W(8), .RD_LAT(2), .TX_TIMEOUT(16), .OVF_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_avail   (rx_avail),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_busy    (tx_busy),
    .fifo_datin (fifo_datin),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .fifo_rd    (fifo_rd),
    .fifo_datout(fifo_datout),
    .fifo_empy  (fifo_empy),
    .drain_en   (drain_en),
    .ovf_clr    (ovf_clr),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  // FIFO model with 2-cycle read latency, plus a UART that stays busy 3 cycles after tx_wr
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ab_cnt <= !auto_en ? 0 : tx_wr ? 3 : (ab_cnt > 0 ? ab_cnt - 1 : 0);
    if (fifo_rd) begin
      if (popped == pushed) rd_empty <= rd_empty + 1;
      else begin
        d1 <= mem[popped % 8];
        popped <= popped + 1;
      end
    end
    fifo_datout <= d1;
  end

  always @(negedge clk) begin
    if (fifo_wr) n_wr <= n_wr + 1;
    if (fifo_rd) begin
      n_rd <= n_rd + 1;
      rd_cyc <= cyc;
    end
    if (tx_wr) begin
      n_tx <= n_tx + 1;
      tx_cyc <= cyc;
      last_txd <= tx_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[pushed % 8] = b;
    pushed++;
  endtask

  task automatic wait_tx(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = tx_wr;
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && busy; i++) @(negedge clk);
    chk(name, busy, 0);
  endtask

  initial begin
    vec_t v [6];
    logic ok;
    int b_wr, b_rd, b_tx;
    v[0] = '{8'hA5, 1'b0, 10, 1'b0, 1, 8'hA5, 8'h00};
    v[1] = '{8'h3C, 1'b0, 1,  1'b0, 1, 8'h3C, 8'h00};
    v[2] = '{8'h77, 1'b1, 3,  1'b0, 0, 8'h3C, 8'h01};
    v[3] = '{8'h11, 1'b1, 1,  1'b0, 0, 8'h3C, 8'h02};
    v[4] = '{8'h22, 1'b1, 1,  1'b1, 0, 8'h3C, 8'h01};
    v[5] = '{8'h5A, 1'b0, 2,  1'b1, 1, 8'h5A, 8'h00};

    rst = 1'b0; rx_avail = 1'b1; rx_data = 8'hEE;
    cycles(4);
    chk("reset_outs", {tx_wr, fifo_wr, fifo_rd, busy, tx_data, fifo_datin, ovf_cnt}, 0);
    rx_avail = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(5);
    chk("reset_no_wr", n_wr, 0);

    foreach (v[i]) begin
      b_wr = n_wr;
      rx_data = v[i].data; fifo_full = v[i].full; ovf_clr = v[i].clr; rx_avail = 1'b1;
      cycles(1);
      ovf_clr = 1'b0;
      cycles(v[i].hold - 1);
      rx_avail = 1'b0;
      cycles(3);
      chk($sformatf("vec%0d_wr", i), n_wr - b_wr, v[i].exp_wr);
      chk($sformatf("vec%0d_din", i), fifo_datin, v[i].exp_din);
      chk($sformatf("vec%0d_ovf", i), ovf_cnt, v[i].exp_ovf);
    end

    b_wr = n_wr; fifo_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx_avail = 1'b1; cycles(1);
      rx_avail = 1'b0; cycles(1);
      if (i == 253) chk("ovf_254", ovf_cnt, 8'hFE);
      if (i == 254) chk("ovf_255", ovf_cnt, 8'hFF);
    end
    cycles(2);
    chk("ovf_sat", ovf_cnt, 8'hFF);
    chk("ovf_no_wr", n_wr - b_wr, 0);
    ovf_clr = 1'b1; cycles(1);
    ovf_clr = 1'b0; cycles(1);
    chk("ovf_clr", ovf_cnt, 0);
    fifo_full = 1'b0;

    auto_en = 1'b1; push(8'h3C);
    b_rd = n_rd; b_tx = n_tx; drain_en = 1'b1;
    wait_tx(20, ok);
    chk("drain_txwr", ok, 1);
    chk("drain_txdata", tx_data, 8'h3C);
    drain_en = 1'b0;
    wait_idle("drain_idle", 30);
    cycles(2);
    chk("drain_rd_once", n_rd - b_rd, 1);
    chk("drain_tx_once", n_tx - b_tx, 1);
    chk("drain_latency", tx_cyc - rd_cyc, 3);
    chk("drain_last_txd", last_txd, 8'h3C);

    auto_en = 1'b0; hold_busy = 1'b1; push(8'h81);
    b_tx = n_tx; drain_en = 1'b1;
    cycles(12);
    chk("bp_no_txwr", n_tx - b_tx, 0);
    chk("bp_busy", busy, 1);
    drain_en = 1'b0; hold_busy = 1'b0;
    wait_tx(5, ok);
    chk("bp_txwr", ok, 1);
    chk("bp_txdata", tx_data, 8'h81);
    cycles(16);
    chk("to_still_busy", busy, 1);
    cycles(1);
    chk("to_idle", busy, 0);

    auto_en = 1'b1; push(8'h42);
    rx_data = 8'h6E; drain_en = 1'b1; rx_avail = 1'b1;
    cycles(1);
    chk("conc_wr_rd", {fifo_wr, fifo_rd}, 2'b11);
    chk("conc_din", fifo_datin, 8'h6E);
    rx_avail = 1'b0; drain_en = 1'b0;
    wait_idle("conc_idle", 30);

    push(8'h99); push(8'h55);
    b_rd = n_rd; drain_en = 1'b1;
    cycles(1);
    chk("drop_pop", fifo_rd, 1);
    cycles(1);
    drain_en = 1'b0;
    wait_tx(10, ok);
    chk("drop_txwr", ok, 1);
    chk("drop_txdata", tx_data, 8'h99);
    wait_idle("drop_idle", 30);
    cycles(4);
    chk("drop_no_new_pop", n_rd - b_rd, 1);
    chk("no_rd_when_empty", rd_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
